// File: rtl/seg_display_ctrl.sv
// Sequencing controller for seven_seg_unit: shares the display between CPU output
// values (each held for at least HOLD_CYCLES) and the switch-input prompt.
module seg_display_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_WIDTH   = $clog2(HOLD_CYCLES) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_value,
    output logic        cpu_ack,
    input  logic        in_req,
    output logic [31:0] display_value,
    output logic        switch_enable,
    output logic        input_enable,
    output logic        busy
);

    typedef enum logic [1:0] {
        OFF,
        SHOW,
        HOLD,
        INPUT
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= OFF;
            count         <= '0;
            display_value <= 32'h0;
            cpu_ack       <= 1'b0;
            switch_enable <= 1'b0;
            input_enable  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                OFF, SHOW: begin
                    // A CPU value beats a simultaneous input prompt; the prompt is
                    // picked up once the hold expires if in_req is still high.
                    if (cpu_req) begin
                        display_value <= cpu_value;
                        cpu_ack       <= 1'b1;
                        count         <= CNT_WIDTH'(HOLD_CYCLES - 1);
                        state         <= HOLD;
                        input_enable  <= 1'b1;
                        switch_enable <= 1'b0;
                        busy          <= 1'b1;
                    end else if (in_req) begin
                        state         <= INPUT;
                        input_enable  <= 1'b1;
                        switch_enable <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                HOLD: begin
                    if (count == '0) begin
                        state <= SHOW;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - CNT_WIDTH'(1);
                    end
                end
                INPUT: begin
                    if (!in_req) begin
                        state         <= SHOW;
                        switch_enable <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= OFF;
                    input_enable  <= 1'b0;
                    switch_enable <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with HOLD_CYCLES=4; accepted values are
// tracked in a scoreboard queue and compared against display_value on each ack.
module tb_seg_display_ctrl;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_value = 32'h0;
    logic        cpu_ack;
    logic        in_req = 1'b0;
    logic [31:0] display_value;
    logic        switch_enable;
    logic        input_enable;
    logic        busy;

    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_val;

    seg_display_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_value(cpu_value),
        .cpu_ack(cpu_ack),
        .in_req(in_req),
        .display_value(display_value),
        .switch_enable(switch_enable),
        .input_enable(input_enable),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until cpu_ack is seen, or -1 on timeout.
    task automatic wait_ack(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (cpu_ack === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        n_compared++;
        if ({cpu_ack, switch_enable, input_enable, busy} !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got ack/sw/in/busy=%b, expected 0000",
                     {cpu_ack, switch_enable, input_enable, busy});
        end
        n_compared++;
        if (display_value !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_display: got %h, expected 00000000", display_value);
        end
    endtask

    task automatic test_first_value();
        cpu_req   = 1'b1;
        cpu_value = 32'h8000_0000;
        sb.push_back(cpu_value);
        step();
        cpu_req = 1'b0;
        n_compared++;
        if ({cpu_ack, input_enable, busy} !== 3'b111) begin
            n_mismatched++;
            $display("[TB] FAIL first_accept_flags: got ack/in/busy=%b, expected 111",
                     {cpu_ack, input_enable, busy});
        end
        exp_val = sb.pop_front();
        n_compared++;
        if (display_value !== exp_val) begin
            n_mismatched++;
            $display("[TB] FAIL first_display: got %h, expected %h", display_value, exp_val);
        end
        for (int i = 1; i < HOLD; i++) begin
            step();
            n_compared++;
            if ({cpu_ack, busy} !== 2'b01) begin
                n_mismatched++;
                $display("[TB] FAIL first_hold_%0d: got ack/busy=%b, expected 01", i, {cpu_ack, busy});
            end
        end
        step();
        n_compared++;
        if ({busy, input_enable} !== 2'b01) begin
            n_mismatched++;
            $display("[TB] FAIL first_release: got busy/in=%b, expected 01", {busy, input_enable});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        cpu_req   = 1'b1;
        cpu_value = 32'h1;
        sb.push_back(cpu_value);
        wait_ack(10, n);
        n_compared++;
        if (n != 1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_first_latency: got %0d edges, expected 1", n);
        end
        exp_val = sb.pop_front();
        n_compared++;
        if (display_value !== exp_val) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_display_1: got %h, expected %h", display_value, exp_val);
        end
        cpu_value = 32'h2;
        sb.push_back(cpu_value);
        wait_ack(20, n);
        cpu_req = 1'b0;
        n_compared++;
        if (n != HOLD + 1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ack_spacing: got %0d edges, expected %0d", n, HOLD + 1);
        end
        exp_val = sb.pop_front();
        n_compared++;
        if (display_value !== exp_val) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_display_2: got %h, expected %h", display_value, exp_val);
        end
        repeat (HOLD) step();
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_release: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_in_and_cpu();
        in_req    = 1'b1;
        cpu_req   = 1'b1;
        cpu_value = 32'hABCD;
        sb.push_back(cpu_value);
        step();
        cpu_req = 1'b0;
        n_compared++;
        if ({cpu_ack, switch_enable} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL inq_cpu_wins: got ack/sw=%b, expected 10", {cpu_ack, switch_enable});
        end
        exp_val = sb.pop_front();
        n_compared++;
        if (display_value !== exp_val) begin
            n_mismatched++;
            $display("[TB] FAIL inq_display: got %h, expected %h", display_value, exp_val);
        end
        for (int i = 1; i < HOLD; i++) begin
            step();
            n_compared++;
            if ({busy, switch_enable} !== 2'b10) begin
                n_mismatched++;
                $display("[TB] FAIL inq_hold_%0d: got busy/sw=%b, expected 10", i, {busy, switch_enable});
            end
        end
        step();
        n_compared++;
        if ({busy, switch_enable} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL inq_show: got busy/sw=%b, expected 00", {busy, switch_enable});
        end
        step();
        n_compared++;
        if ({busy, switch_enable, input_enable} !== 3'b111) begin
            n_mismatched++;
            $display("[TB] FAIL inq_input: got busy/sw/in=%b, expected 111",
                     {busy, switch_enable, input_enable});
        end
        in_req = 1'b0;
        step();
        n_compared++;
        if ({busy, switch_enable, input_enable} !== 3'b001 || display_value !== 32'hABCD) begin
            n_mismatched++;
            $display("[TB] FAIL inq_leave: got busy/sw/in=%b disp=%h, expected 001 disp=0000abcd",
                     {busy, switch_enable, input_enable}, display_value);
        end
    endtask

    task automatic test_req_during_input();
        in_req = 1'b1;
        step();
        cpu_req   = 1'b1;
        cpu_value = 32'h5555_AAAA;
        sb.push_back(cpu_value);
        for (int i = 0; i < 3; i++) begin
            step();
            n_compared++;
            if ({cpu_ack, switch_enable} !== 2'b01) begin
                n_mismatched++;
                $display("[TB] FAIL input_ignore_%0d: got ack/sw=%b, expected 01", i, {cpu_ack, switch_enable});
            end
        end
        in_req = 1'b0;
        step();
        n_compared++;
        if ({cpu_ack, switch_enable} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL input_exit: got ack/sw=%b, expected 00", {cpu_ack, switch_enable});
        end
        step();
        cpu_req = 1'b0;
        n_compared++;
        if (cpu_ack !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL input_then_ack: got ack=%b, expected 1", cpu_ack);
        end
        exp_val = sb.pop_front();
        n_compared++;
        if (display_value !== exp_val) begin
            n_mismatched++;
            $display("[TB] FAIL input_then_display: got %h, expected %h", display_value, exp_val);
        end
        repeat (HOLD) step();
    endtask

    task automatic test_reset_mid_hold();
        cpu_req   = 1'b1;
        cpu_value = 32'hDEAD_BEEF;
        sb.push_back(cpu_value);
        step();
        cpu_req = 1'b0;
        exp_val = sb.pop_front();
        n_compared++;
        if (cpu_ack !== 1'b1 || display_value !== exp_val) begin
            n_mismatched++;
            $display("[TB] FAIL rst_pre_accept: got ack=%b disp=%h, expected 1 %h",
                     cpu_ack, display_value, exp_val);
        end
        step();
        rst       = 1'b1;
        cpu_req   = 1'b1;
        cpu_value = 32'h1234;
        step();
        n_compared++;
        if ({cpu_ack, input_enable, busy, switch_enable} !== 4'b0000 || display_value !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_hold: got ack/in/busy/sw=%b disp=%h, expected 0000 00000000",
                     {cpu_ack, input_enable, busy, switch_enable}, display_value);
        end
        rst     = 1'b0;
        cpu_req = 1'b0;
        step();
        n_compared++;
        if ({cpu_ack, input_enable} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL rst_stays_off: got ack/in=%b, expected 00", {cpu_ack, input_enable});
        end
    endtask

    initial begin
        test_reset();
        test_first_value();
        test_back_to_back();
        test_in_and_cpu();
        test_req_during_input();
        test_reset_mid_hold();
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Sequencing controller for the seven-segment display unit. It sits between the CPU's MMIO/syscall output path and `seven_seg_unit`, and drives that unit's `display_value`, `switch_enable` and `input_enable` inputs. It shares the display between two users: CPU output values and the CPU's "waiting for switch input" prompt. Each CPU value stays on screen for a guaranteed minimum hold time before the display can be reused.

## Interface
- `HOLD_CYCLES`, default 50_000_000: minimum number of cycles a newly accepted CPU value is held on the display; legal range ≥1.
- `CNT_WIDTH`, default `$clog2(HOLD_CYCLES)+1`: width of the hold counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cpu_req`  in  1  CPU has a value to display; held high until `cpu_ack`.
- `cpu_value`  in  32  value to display; stable while `cpu_req` is high.
- `cpu_ack`  out  1  one-cycle pulse: `cpu_value` has been latched.
- `in_req`  in  1  level; CPU is stalled waiting for switch input.
- `display_value`  out  32  to `seven_seg_unit.display_value`.
- `switch_enable`  out  1  to `seven_seg_unit`; 1 = unit shows live switch word.
- `input_enable`  out  1  to `seven_seg_unit`; 1 = display lit, 0 = blanked.
- `busy`  out  1  high in HOLD or INPUT.

## Operation
States: OFF, SHOW, HOLD, INPUT.

Outputs per state (all registered):
- OFF: `input_enable`=0, `switch_enable`=0.
- SHOW, HOLD: `input_enable`=1, `switch_enable`=0.
- INPUT: `input_enable`=1, `switch_enable`=1.
- `display_value` is a register. It changes only on CPU acceptance and is retained in every other state.

Acceptance (OFF or SHOW, `cpu_req`=1):
- latch `display_value`←`cpu_value`;
- pulse `cpu_ack`;
- load counter with `HOLD_CYCLES-1`;
- go to HOLD.

Other transitions:
- HOLD: if counter==0, go to SHOW; else decrement. `cpu_req` and `in_req` are ignored (not acked) while in HOLD.
- OFF/SHOW with `in_req`=1 and `cpu_req`=0: go to INPUT.
- OFF/SHOW with `in_req`=1 and `cpu_req`=1 in the same cycle: CPU wins, go to HOLD. INPUT is entered after HOLD expires, once SHOW samples `in_req` still high.
- INPUT with `in_req`=0: go to SHOW, with the previous `display_value` intact. `cpu_req` is ignored in INPUT.

Other rules:
- OFF is left only by an acceptance or by `in_req`; the controller never returns to OFF except via reset.
- Counter arithmetic is unsigned. It never underflows, because the decrement is gated by the counter==0 test.

## Timing
- Reset values: state=OFF, `display_value`=32'h0, `cpu_ack`=0, `switch_enable`=0, `input_enable`=0, `busy`=0, counter=0.
- `rst` has priority over all inputs. Reset mid-HOLD or mid-INPUT returns to OFF on the next edge; a pending `cpu_req` is not acked in the reset cycle.
- Acceptance latency: `cpu_req` sampled high at edge k (state SHOW/OFF). At edge k, `cpu_ack`=1, `display_value` is updated and state becomes HOLD. `cpu_ack` returns to 0 at edge k+1.
- HOLD lasts exactly `HOLD_CYCLES` cycles. State is SHOW from edge k+`HOLD_CYCLES`.
- Requester rule: drop `cpu_req` or present the next value in the cycle after `cpu_ack`. A `cpu_req` still high during HOLD is a new request and is accepted on the first SHOW cycle.
- Minimum spacing between consecutive `cpu_ack` pulses is `HOLD_CYCLES`+1 cycles.
- `in_req` rises in SHOW → `switch_enable`=1 one edge later. `in_req` falls in INPUT → `switch_enable`=0 one edge later.
- `HOLD_CYCLES`=1: HOLD lasts one cycle.

## Test plan
Bench uses `HOLD_CYCLES`=4.

1. Reset, then idle 5 cycles → all outputs 0, state OFF, `busy`=0.
2. `cpu_req`=1, `cpu_value`=32'h80000000 from OFF → `cpu_ack` for one cycle. `display_value`=32'h80000000 and `input_enable`=1 on that same edge. `busy`=1 for 4 cycles, then 0.
3. `cpu_req` held high with `cpu_value`=32'h1 then 32'h2 back-to-back → two `cpu_ack` pulses exactly 5 cycles apart; `display_value` steps 32'h1 → 32'h2.
4. `in_req`=1 and `cpu_req`=1 (32'hABCD) in the same SHOW cycle → ack first, HOLD for 4 cycles, then INPUT with `switch_enable`=1. Dropping `in_req` → SHOW with `display_value` still 32'hABCD.
5. `cpu_req` asserted during INPUT → no ack until `in_req` falls. Ack on the first SHOW cycle.
6. `rst` asserted in the 2nd HOLD cycle → next edge: OFF, `display_value`=0, `input_enable`=0, no `cpu_ack`.
